// File: rtl/sr_pulse_driver_if.sv
// sr_pulse_driver_if: request, S/R drive and Q feedback bundle for the S-R pulse driver
interface sr_pulse_driver_if;
  logic req_valid;
  logic req_level;
  logic req_ready;
  logic S;
  logic R;
  logic q_fb;
  logic busy;
  logic done;
  logic err;
  modport master (output req_valid, req_level, q_fb, input req_ready, S, R, busy, done, err);
  modport slave (input req_valid, req_level, q_fb, output req_ready, S, R, busy, done, err);
endinterface

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: turns a set/clear request into a timed S or R pulse, then verifies Q or times out
module sr_pulse_driver #(
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT_CYC = 4
) (
  input logic clk,
  input logic rst,
  sr_pulse_driver_if.slave bus
);
  localparam int M1 = PULSE_CYC > GAP_CYC ? PULSE_CYC : GAP_CYC;
  localparam int MX = M1 > TIMEOUT_CYC ? M1 : TIMEOUT_CYC;
  localparam int CW = $clog2(MX + 1);
  localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] G_LD = CW'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  localparam logic [CW-1:0] V_LD = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, PULSE, GAP, VERIFY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic tgt;
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  // counters load "remaining minus one" on entry so a zero test marks the last cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tgt <= 1'b0;
      bus.S <= 1'b0;
      bus.R <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          tgt <= bus.req_level;
          bus.err <= 1'b0;
          bus.S <= bus.req_level;
          bus.R <= ~bus.req_level;
          cnt <= P_LD;
          state <= PULSE;
        end
        PULSE: if (cnt == '0) begin
          bus.S <= 1'b0;
          bus.R <= 1'b0;
          state <= GAP_CYC == 0 ? VERIFY : GAP;
          cnt <= GAP_CYC == 0 ? V_LD : G_LD;
        end else cnt <= cnt - 1'b1;
        GAP: if (cnt == '0) begin
          state <= VERIFY;
          cnt <= V_LD;
        end else cnt <= cnt - 1'b1;
        VERIFY: if (bus.q_fb == tgt || cnt == '0) begin
          state <= IDLE;
          cnt <= '0;
          bus.done <= 1'b1;
          bus.err <= bus.q_fb != tgt;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: directed scenario tasks for sr_pulse_driver with default parameters
module tb_sr_pulse_driver;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  sr_pulse_driver_if bus ();
  sr_pulse_driver dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // cycle n is the period following the (n-1)th rising edge after the accept edge
  always @(negedge clk) begin
    checks++;
    if (bus.S & bus.R) begin
      errors++;
      $display("FAIL s_and_r at %0t got S=%b R=%b exp not both 1", $time, bus.S, bus.R);
    end
  end

  task test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_level = 1'b0;
    bus.q_fb = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.busy, bus.S, bus.R, bus.done, bus.err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset got %b exp 100000", {bus.req_ready, bus.busy, bus.S, bus.R, bus.done, bus.err});
    end
    rst = 1'b0;
  endtask

  task test_set;
    bus.q_fb = 1'b0;
    bus.req_level = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.S, bus.R} !== {c == 1 || c == 2, 1'b0}) begin
        errors++;
        $display("FAIL set_sr c%0d got %b%b exp %b0", c, bus.S, bus.R, c == 1 || c == 2);
      end
      checks++;
      if ({bus.done, bus.req_ready} !== {c == 5, c >= 5}) begin
        errors++;
        $display("FAIL set_done_ready c%0d got %b%b exp %b%b", c, bus.done, bus.req_ready, c == 5, c >= 5);
      end
      if (c == 5) begin
        checks++;
        if (bus.err !== 1'b0) begin
          errors++;
          $display("FAIL set_err got %b exp 0", bus.err);
        end
      end
      if (c == 2) bus.q_fb = 1'b1;
    end
  endtask

  task test_clear;
    bus.q_fb = 1'b1;
    bus.req_level = 1'b0;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.S, bus.R} !== {1'b0, c == 1 || c == 2}) begin
        errors++;
        $display("FAIL clear_sr c%0d got %b%b exp 0%b", c, bus.S, bus.R, c == 1 || c == 2);
      end
      checks++;
      if ({bus.done, bus.err} !== {c == 5, 1'b0}) begin
        errors++;
        $display("FAIL clear_done_err c%0d got %b%b exp %b0", c, bus.done, bus.err, c == 5);
      end
      if (c == 2) bus.q_fb = 1'b0;
    end
  endtask

  task test_timeout;
    bus.q_fb = 1'b0;
    bus.req_level = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.S, bus.R} !== {c == 1 || c == 2, 1'b0}) begin
        errors++;
        $display("FAIL timeout_sr c%0d got %b%b exp %b0", c, bus.S, bus.R, c == 1 || c == 2);
      end
      checks++;
      if ({bus.done, bus.err} !== {c == 8, c >= 8}) begin
        errors++;
        $display("FAIL timeout_done_err c%0d got %b%b exp %b%b", c, bus.done, bus.err, c == 8, c >= 8);
      end
    end
  endtask

  task test_late_match;
    bus.q_fb = 1'b0;
    bus.req_level = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.done, bus.err} !== {c == 7, 1'b0}) begin
        errors++;
        $display("FAIL late_done_err c%0d got %b%b exp %b0", c, bus.done, bus.err, c == 7);
      end
      checks++;
      if (bus.busy !== (c <= 6)) begin
        errors++;
        $display("FAIL late_busy c%0d got %b exp %b", c, bus.busy, c <= 6);
      end
      if (c == 6) bus.q_fb = 1'b1;
    end
  endtask

  task test_back_to_back;
    bus.q_fb = 1'b1;
    bus.req_level = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.S, bus.R} !== {c == 1 || c == 2 || c == 6 || c == 7, 1'b0}) begin
        errors++;
        $display("FAIL b2b_sr c%0d got %b%b", c, bus.S, bus.R);
      end
      checks++;
      if ({bus.done, bus.busy} !== {c == 5 || c == 10, !(c == 5 || c >= 10)}) begin
        errors++;
        $display("FAIL b2b_done_busy c%0d got %b%b exp %b%b", c, bus.done, bus.busy, c == 5 || c == 10, !(c == 5 || c >= 10));
      end
      if (c == 10) bus.req_valid = 1'b0;
    end
  endtask

  task test_reset_mid_pulse;
    bus.q_fb = 1'b0;
    bus.req_level = 1'b1;
    bus.req_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.S, bus.R, bus.done} !== {c == 1, 2'b00}) begin
        errors++;
        $display("FAIL rst_mid_sr_done c%0d got %b%b%b exp %b00", c, bus.S, bus.R, bus.done, c == 1);
      end
      if (c >= 2) begin
        checks++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
          errors++;
          $display("FAIL rst_mid_ready c%0d got %b%b exp 10", c, bus.req_ready, bus.busy);
        end
      end
      rst = c == 1;
    end
  endtask

  initial begin
    test_reset;
    test_set;
    test_clear;
    test_timeout;
    test_late_match;
    test_back_to_back;
    test_reset_mid_pulse;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
